// File: rtl/vproc_irq_ctrl_pkg.sv
// Shared definitions for the VProc interrupt controller:
// register window indices and bus FSM state encodings.
package vproc_irq_ctrl_pkg;

  localparam logic [2:0] REG_RAW     = 3'd0;
  localparam logic [2:0] REG_PENDING = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_MODE    = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } bus_state_e;

endpackage

// File: rtl/vproc_irq_sync.sv
// Per-line synchroniser chain for asynchronous interrupt sources, plus one
// extra delayed copy so rising edges can be detected in the clk domain.
module vproc_irq_sync #(
  parameter int NUM_IRQ     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] sync_o,
  output logic [NUM_IRQ-1:0] rise_o
);

  logic [NUM_IRQ-1:0] chain_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/vproc_irq_ctrl.sv
// Interrupt controller feeding the VProc Interrupt vector: latches synchronised
// sources as level or edge events, masks them, and exposes a 4-register bus window.
module vproc_irq_ctrl
  import vproc_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               CS,
  input  logic [31:0]        Addr,
  input  logic               WE,
  input  logic               RD,
  input  logic [31:0]        DI,
  output logic [31:0]        DO,
  output logic               WRAck,
  output logic               RDAck,
  output logic [NUM_IRQ-1:0] Interrupt
);

  logic [NUM_IRQ-1:0] sync, rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] w1c;
  logic [31:0]        do_q, rdata;
  logic               wrack_q, rdack_q;
  logic               wr_en, rd_en;
  logic [2:0]         idx;
  bus_state_e         state_q, state_d;
  logic               unused_bits;

  vproc_irq_sync #(
    .NUM_IRQ    (NUM_IRQ),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .irq_i (irq_src),
    .sync_o(sync),
    .rise_o(rise)
  );

  assign idx         = Addr[4:2];
  assign unused_bits = ^{Addr[31:5], Addr[1:0], DI};

  // An access happens only on the IDLE->ACK edge; a simultaneous WE and RD is a write.
  assign wr_en = (state_q == ST_IDLE) && CS && WE;
  assign rd_en = (state_q == ST_IDLE) && CS && RD && !WE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (CS && (WE || RD)) state_d = ST_ACK;
      ST_ACK:  state_d = (WE || RD) ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!(WE || RD)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_RAW:     rdata = 32'(sync);
      REG_PENDING: rdata = 32'(pending_q);
      REG_ENABLE:  rdata = 32'(enable_q);
      REG_MODE:    rdata = 32'(mode_q);
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    w1c      = (wr_en && idx == REG_PENDING) ? DI[NUM_IRQ-1:0] : '0;
    enable_d = (wr_en && idx == REG_ENABLE)  ? DI[NUM_IRQ-1:0] : enable_q;
    mode_d   = (wr_en && idx == REG_MODE)    ? DI[NUM_IRQ-1:0] : mode_q;
    // Edge lines hold until cleared, with a fresh rise beating a W1C; level lines track sync.
    pending_d = (mode_q & (rise | (pending_q & ~w1c))) | (~mode_q & sync);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      irq_q     <= '0;
      wrack_q   <= 1'b0;
      rdack_q   <= 1'b0;
      do_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_q     <= pending_q & enable_q;
      wrack_q   <= wr_en;
      rdack_q   <= rd_en;
      do_q      <= rd_en ? rdata : '0;
    end
  end

  assign DO        = do_q;
  assign WRAck     = wrack_q;
  assign RDAck     = rdack_q;
  assign Interrupt = irq_q;

endmodule
